ahb_resp_mux: RTL and testbench
===============================

Name: ahb_resp_mux

Overview:
Data-phase response multiplexer and default slave for the 3-slave AHB-lite bus. It sits directly downstream of the address decoder and consumes its hsel_0/1/2 outputs. It registers the address-phase slave selection while hready is high, then steers the selected slave's hrdata/hreadyout/hresp back to the master in the data phase. Transfers to the unmapped region (haddr[15:14]=2'b11, no hsel asserted) get the AHB two-cycle ERROR response from an internal default slave.

Parameters:
DATA_W, 32, width of hrdata buses
ADDR_W, 16, width of haddr (region bits are haddr[ADDR_W-1:ADDR_W-2])

Ports:
hclk  input  1  bus clock, all state on rising edge
hresetn  input  1  asynchronous active-low reset
htrans  input  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
hsel_0  input  1  decoder select, slave 0
hsel_1  input  1  decoder select, slave 1
hsel_2  input  1  decoder select, slave 2
hrdata_0/1/2  input  DATA_W each  slave read data
hreadyout_0/1/2  input  1 each  slave ready
hresp_0/1/2  input  1 each  slave response (0 OKAY, 1 ERROR)
hrdata  output  DATA_W  muxed read data to master
hready  output  1  muxed ready; also fed back to all slaves as hready
hresp  output  1  muxed response to master

Behaviour:
- Reset: one clock, asynchronous active-low reset (hclk, hresetn). While hresetn=0: data-phase state = DP_IDLE, hready=1, hresp=0, hrdata=0. Reset mid-transfer abandons the transfer with no further outputs from it.
- Outputs are combinational from the data-phase state and the slave inputs. There are no extra wait states beyond what the slaves insert.
- Address-phase sample: on a rising hclk with hready=1, the next state is chosen from hsel/htrans:
  - htrans[1]=0 (IDLE/BUSY): DP_IDLE.
  - hsel_0: DP_S0; else hsel_1: DP_S1; else hsel_2: DP_S2. Priority 0>1>2 if several are asserted, which is illegal but handled deterministically.
  - No hsel asserted with htrans[1]=1: DP_ERR1.
- While hready=0, the state holds. The exception is DP_ERR1, which always advances to DP_ERR2.
- DP_IDLE: hready=1, hresp=0, hrdata=0.
- DP_Sn: hrdata=hrdata_n, hready=hreadyout_n, hresp=hresp_n. The state is held while hreadyout_n=0.
- DP_ERR1: hready=0, hresp=1, hrdata=0. Next state is always DP_ERR2.
- DP_ERR2: hready=1, hresp=1, hrdata=0. The address phase presented this cycle is sampled normally, so back-to-back unmapped accesses give ERR1,ERR2,ERR1,ERR2.
- Slave error passthrough: the slave's own two-cycle ERROR (hresp=1 with hreadyout 0 then 1) passes through unchanged. No state change occurs until hreadyout_n=1.
- Write transfers are handled identically (hrdata is don't-care to the master but still muxed). hwrite is not needed.
- Unselected slave inputs must never affect the outputs, including X on hrdata_n.
- Latency: a zero-wait slave transfer completes in one data-phase cycle. An unmapped transfer completes in two.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ constants.
  - HRESP_OKAY/ERROR constants.
  - dp_state_t enum: DP_IDLE, DP_S0, DP_S1, DP_S2, DP_ERR1, DP_ERR2.
  - Region constant for the unmapped region (2'b11).
- Sub-module ahb_default_slave: owns the ERR1/ERR2 sequencing. Inputs are start (unmapped active transfer sampled) and hclk/hresetn. Outputs are its hreadyout/hresp, which are muxed like a fourth slave.

Test Plan:
- Reset: hresetn=0 mid DP_S1 wait state -> hready=1, hresp=0, hrdata=0 immediately; after release with htrans=IDLE, outputs stay 1/0/0.
- Slave 0 read: NONSEQ, hsel_0=1, hreadyout_0=1, hrdata_0=32'hDEADBEEF -> next cycle hrdata=32'hDEADBEEF, hready=1, hresp=0.
- Wait states: NONSEQ to slave 2, hreadyout_2 low for 3 cycles -> hready=0 for 3 cycles; the cycle-4 hrdata_2 value appears with hready=1; a held NONSEQ to slave 1 is not sampled until then.
- Unmapped: NONSEQ with no hsel -> cycle1 hready=0/hresp=1, cycle2 hready=1/hresp=1; back-to-back unmapped -> 1/0-1/1 pattern repeats twice.
- Pipelining: NONSEQ slave1 then SEQ slave2 on consecutive cycles, both zero-wait -> hrdata_1 then hrdata_2 on consecutive cycles; hrdata_0 driven X throughout never reaches hrdata.
- IDLE to unmapped region: htrans=IDLE, no hsel -> hready=1, hresp=0 (no ERROR).

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and the data-phase state type used by the
// response multiplexer and its default slave.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // haddr[ADDR_W-1:ADDR_W-2] value that no decoder select covers
    localparam logic [1:0] REGION_UNMAPPED = 2'b11;

    typedef enum logic [2:0] {
        DP_IDLE,
        DP_S0,
        DP_S1,
        DP_S2,
        DP_ERR1,
        DP_ERR2
    } dp_state_t;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped transfers: answers every sampled start with the
// two-cycle AHB ERROR response (ERR1 not ready, ERR2 ready, both ERROR).
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic hclk,
    input  logic hresetn,
    input  logic start,
    output logic hreadyout,
    output logic hresp
);

    logic err1_q;
    logic err2_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, independent of block order.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            err1_q <= 1'b0;
            err2_q <= 1'b0;
        end else begin
            err1_q <= start;
            err2_q <= err1_q;
        end
    end

    assign hreadyout = ~err1_q;
    assign hresp     = (err1_q | err2_q) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-lite data-phase response multiplexer for three slaves plus an internal
// default slave that returns ERROR for transfers with no select asserted.
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [1:0]        htrans,
    input  logic              hsel_0,
    input  logic              hsel_1,
    input  logic              hsel_2,
    input  logic [DATA_W-1:0] hrdata_0,
    input  logic [DATA_W-1:0] hrdata_1,
    input  logic [DATA_W-1:0] hrdata_2,
    input  logic              hreadyout_0,
    input  logic              hreadyout_1,
    input  logic              hreadyout_2,
    input  logic              hresp_0,
    input  logic              hresp_1,
    input  logic              hresp_2,
    output logic [DATA_W-1:0] hrdata,
    output logic              hready,
    output logic              hresp
);

    // The decoder derives selects from the top region bits of haddr.
    if (ADDR_W < $bits(REGION_UNMAPPED) + 1) begin : g_bad_addr_w
        $error("ADDR_W too small to hold the region field");
    end

    dp_state_t dp_state_q;
    dp_state_t dp_state_d;
    dp_state_t addr_sel;
    logic      ds_start;
    logic      ds_hreadyout;
    logic      ds_hresp;

    // Address-phase decode; selects only matter for active transfers.
    always_comb begin
        addr_sel = DP_IDLE;
        unique case (htrans)
            HTRANS_IDLE, HTRANS_BUSY: addr_sel = DP_IDLE;
            HTRANS_NONSEQ, HTRANS_SEQ: begin
                if (hsel_0)      addr_sel = DP_S0;
                else if (hsel_1) addr_sel = DP_S1;
                else if (hsel_2) addr_sel = DP_S2;
                else             addr_sel = DP_ERR1;
            end
            default: addr_sel = DP_IDLE;
        endcase
    end

    // NOTE: every always_comb output gets a default first, so no path through
    // the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        dp_state_d = dp_state_q;
        if (dp_state_q == DP_ERR1) begin
            dp_state_d = DP_ERR2;
        end else if (hready) begin
            dp_state_d = addr_sel;
        end
    end

    assign ds_start = hready && (dp_state_q != DP_ERR1) && (addr_sel == DP_ERR1);

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_state_q <= DP_IDLE;
        end else begin
            dp_state_q <= dp_state_d;
        end
    end

    ahb_default_slave u_default_slave (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .start     (ds_start),
        .hreadyout (ds_hreadyout),
        .hresp     (ds_hresp)
    );

    // Only the slave owning the data phase is ever routed, so X on the others
    // cannot leak through.
    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        unique case (dp_state_q)
            DP_IDLE: ;
            DP_S0: begin
                hrdata = hrdata_0;
                hready = hreadyout_0;
                hresp  = hresp_0;
            end
            DP_S1: begin
                hrdata = hrdata_1;
                hready = hreadyout_1;
                hresp  = hresp_1;
            end
            DP_S2: begin
                hrdata = hrdata_2;
                hready = hreadyout_2;
                hresp  = hresp_2;
            end
            DP_ERR1, DP_ERR2: begin
                hready = ds_hreadyout;
                hresp  = ds_hresp;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed self-checking bench for ahb_resp_mux: reset, zero-wait and waited
// slave transfers, pipelining, unmapped ERROR sequencing and slave errors.
module tb_ahb_resp_mux;

    localparam int DATA_W = 32;

    logic              hclk;
    logic              hresetn;
    logic [1:0]        htrans;
    logic              hsel_0, hsel_1, hsel_2;
    logic [DATA_W-1:0] hrdata_0, hrdata_1, hrdata_2;
    logic              hreadyout_0, hreadyout_1, hreadyout_2;
    logic              hresp_0, hresp_1, hresp_2;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;

    int n_checks = 0;
    int n_fail   = 0;

    ahb_resp_mux #(.DATA_W(DATA_W), .ADDR_W(16)) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .htrans      (htrans),
        .hsel_0      (hsel_0),
        .hsel_1      (hsel_1),
        .hsel_2      (hsel_2),
        .hrdata_0    (hrdata_0),
        .hrdata_1    (hrdata_1),
        .hrdata_2    (hrdata_2),
        .hreadyout_0 (hreadyout_0),
        .hreadyout_1 (hreadyout_1),
        .hreadyout_2 (hreadyout_2),
        .hresp_0     (hresp_0),
        .hresp_1     (hresp_1),
        .hresp_2     (hresp_2),
        .hrdata      (hrdata),
        .hready      (hready),
        .hresp       (hresp)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic exp_rdy, input logic exp_rsp,
                         input logic [DATA_W-1:0] exp_data);
        #1;
        n_checks++;
        assert (hready === exp_rdy && hresp === exp_rsp && hrdata === exp_data)
        else begin
            n_fail++;
            $error("FAIL %s observed hready=%b hresp=%b hrdata=%h expected hready=%b hresp=%b hrdata=%h",
                   tag, hready, hresp, hrdata, exp_rdy, exp_rsp, exp_data);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr(input logic [1:0] tr, input logic s0, input logic s1, input logic s2);
        htrans = tr;
        hsel_0 = s0;
        hsel_1 = s1;
        hsel_2 = s2;
    endtask

    initial begin
        hresetn     = 1'b0;
        addr(2'b00, 1'b0, 1'b0, 1'b0);
        hrdata_0    = '0;
        hrdata_1    = '0;
        hrdata_2    = '0;
        hreadyout_0 = 1'b1;
        hreadyout_1 = 1'b1;
        hreadyout_2 = 1'b1;
        hresp_0     = 1'b0;
        hresp_1     = 1'b0;
        hresp_2     = 1'b0;

        check("reset_state", 1'b1, 1'b0, '0);
        cyc();
        cyc();
        hresetn = 1'b1;
        cyc();
        check("idle_after_reset", 1'b1, 1'b0, '0);

        // Slave 0 zero-wait read.
        addr(2'b10, 1'b1, 1'b0, 1'b0);
        hrdata_0 = 32'hDEADBEEF;
        check("s0_addr_phase", 1'b1, 1'b0, '0);
        cyc();
        addr(2'b10, 1'b0, 1'b0, 1'b1);
        check("s0_data_phase", 1'b1, 1'b0, 32'hDEADBEEF);

        // Slave 2 with three wait states; NONSEQ to slave 1 held meanwhile.
        cyc();
        addr(2'b10, 1'b0, 1'b1, 1'b0);
        hreadyout_2 = 1'b0;
        hrdata_1    = 32'hAAAA0001;
        for (int i = 0; i < 3; i++) begin
            hrdata_2 = 32'h0000_1110 + DATA_W'(i);
            check($sformatf("s2_wait_%0d", i), 1'b0, 1'b0, 32'h0000_1110 + DATA_W'(i));
            cyc();
        end
        hreadyout_2 = 1'b1;
        hrdata_2    = 32'hCAFEF00D;
        check("s2_done", 1'b1, 1'b0, 32'hCAFEF00D);
        cyc();
        addr(2'b00, 1'b0, 1'b0, 1'b0);
        hrdata_1 = 32'h12345678;
        check("s1_after_wait", 1'b1, 1'b0, 32'h12345678);
        cyc();

        // Single unmapped transfer.
        addr(2'b10, 1'b0, 1'b0, 1'b0);
        check("unmapped_addr_phase", 1'b1, 1'b0, '0);
        cyc();
        addr(2'b00, 1'b0, 1'b0, 1'b0);
        check("unmapped_err1", 1'b0, 1'b1, '0);
        cyc();
        check("unmapped_err2", 1'b1, 1'b1, '0);
        cyc();
        check("unmapped_back_idle", 1'b1, 1'b0, '0);

        // Back-to-back unmapped transfers.
        addr(2'b10, 1'b0, 1'b0, 1'b0);
        cyc();
        check("b2b_err1_a", 1'b0, 1'b1, '0);
        cyc();
        check("b2b_err2_a", 1'b1, 1'b1, '0);
        addr(2'b11, 1'b0, 1'b0, 1'b0);
        cyc();
        addr(2'b00, 1'b0, 1'b0, 1'b0);
        check("b2b_err1_b", 1'b0, 1'b1, '0);
        cyc();
        check("b2b_err2_b", 1'b1, 1'b1, '0);
        cyc();
        check("b2b_idle", 1'b1, 1'b0, '0);

        // Pipelined slave 1 then slave 2 with slave 0 driving X.
        hrdata_0    = 'x;
        hreadyout_0 = 1'bx;
        hresp_0     = 1'bx;
        hrdata_1    = 32'h11111111;
        hrdata_2    = 32'h22222222;
        addr(2'b10, 1'b0, 1'b1, 1'b0);
        cyc();
        addr(2'b11, 1'b0, 1'b0, 1'b1);
        check("pipe_s1", 1'b1, 1'b0, 32'h11111111);
        cyc();
        addr(2'b00, 1'b0, 1'b0, 1'b0);
        check("pipe_s2", 1'b1, 1'b0, 32'h22222222);
        cyc();
        check("pipe_idle", 1'b1, 1'b0, '0);

        // IDLE and BUSY with no select must not raise ERROR.
        addr(2'b01, 1'b0, 1'b0, 1'b0);
        cyc();
        check("busy_unmapped", 1'b1, 1'b0, '0);
        cyc();
        check("busy_unmapped_2", 1'b1, 1'b0, '0);

        // Multiple selects: slave 0 wins.
        hrdata_0    = 32'h0BADF00D;
        hreadyout_0 = 1'b1;
        hresp_0     = 1'b0;
        addr(2'b10, 1'b1, 1'b1, 1'b1);
        cyc();
        addr(2'b00, 1'b0, 1'b0, 1'b0);
        check("priority_s0", 1'b1, 1'b0, 32'h0BADF00D);
        cyc();

        // Slave 1 two-cycle ERROR passes through unchanged.
        addr(2'b10, 1'b0, 1'b1, 1'b0);
        cyc();
        addr(2'b10, 1'b1, 1'b0, 1'b0);
        hreadyout_1 = 1'b0;
        hresp_1     = 1'b1;
        check("slave_err_c1", 1'b0, 1'b1, 32'h11111111);
        cyc();
        hreadyout_1 = 1'b1;
        check("slave_err_c2", 1'b1, 1'b1, 32'h11111111);
        cyc();
        addr(2'b00, 1'b0, 1'b0, 1'b0);
        hresp_1 = 1'b0;
        check("after_slave_err_s0", 1'b1, 1'b0, 32'h0BADF00D);
        cyc();

        // Reset in the middle of a slave 1 wait state.
        addr(2'b10, 1'b0, 1'b1, 1'b0);
        cyc();
        addr(2'b00, 1'b0, 1'b0, 1'b0);
        hreadyout_1 = 1'b0;
        check("s1_wait_before_reset", 1'b0, 1'b0, 32'h11111111);
        hresetn = 1'b0;
        check("reset_mid_wait", 1'b1, 1'b0, '0);
        cyc();
        hresetn = 1'b1;
        cyc();
        check("idle_after_mid_reset", 1'b1, 1'b0, '0);
        cyc();
        check("idle_after_mid_reset_2", 1'b1, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
